// File: rtl/leve_axir_arb.sv
`default_nettype none
// ============================================================================
// Module   : leve_axir_arb
// Purpose  : Two-to-one AXI read-channel arbiter. Requester 0 (instruction
//            burst buffer) and requester 1 (load/store unit) share one read
//            initiator port. A grant covers a whole burst, from the AR
//            handshake to the R beat carrying RLAST. Fairness is round-robin.
//            Only one transaction is outstanding at a time, so no ID routing
//            is needed.
// Ports    : CLK, RSTn (asynchronous, active-low)
//            S0_* / S1_*  requester-side AR and R channels
//            M_*          memory-side AR and R channels
//            GNT          one-hot current owner (00 = none)
//            BUSY         high whenever a burst is being served
// Revision : 1.0  initial release
// ============================================================================
module leve_axir_arb #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  // requester 0 (ifetch)
  input  logic              S0_ARVALID,
  output logic              S0_ARREADY,
  input  logic [ADDR_W-1:0] S0_ARADDR,
  input  logic [1:0]        S0_ARBURST,
  input  logic [LEN_W-1:0]  S0_ARLEN,
  output logic              S0_RVALID,
  input  logic              S0_RREADY,
  output logic [DATA_W-1:0] S0_RDATA,
  output logic              S0_RLAST,
  // requester 1 (data)
  input  logic              S1_ARVALID,
  output logic              S1_ARREADY,
  input  logic [ADDR_W-1:0] S1_ARADDR,
  input  logic [1:0]        S1_ARBURST,
  input  logic [LEN_W-1:0]  S1_ARLEN,
  output logic              S1_RVALID,
  input  logic              S1_RREADY,
  output logic [DATA_W-1:0] S1_RDATA,
  output logic              S1_RLAST,
  // memory side
  output logic              M_ARVALID,
  input  logic              M_ARREADY,
  output logic [ADDR_W-1:0] M_ARADDR,
  output logic [1:0]        M_ARBURST,
  output logic [LEN_W-1:0]  M_ARLEN,
  input  logic              M_RVALID,
  output logic              M_RREADY,
  input  logic [DATA_W-1:0] M_RDATA,
  input  logic              M_RLAST,
  // status
  output logic [1:0]        GNT,
  output logic              BUSY
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic       pri_q, pri_d;     // requester favoured on a tie
  logic       sel1;             // granted requester is 1

  assign sel1 = gnt_q[1];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      pri_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      pri_q   <= pri_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    pri_d   = pri_q;
    case (state_q)
      ST_IDLE: begin
        if (S0_ARVALID || S1_ARVALID) begin
          state_d = ST_ADDR;
          if (S0_ARVALID && S1_ARVALID)
            gnt_d = pri_q ? 2'b10 : 2'b01;
          else
            gnt_d = S1_ARVALID ? 2'b10 : 2'b01;
        end
      end
      ST_ADDR: begin
        if (M_ARVALID && M_ARREADY)
          state_d = ST_DATA;
      end
      ST_DATA: begin
        if (M_RVALID && M_RREADY && M_RLAST) begin
          state_d = ST_IDLE;
          gnt_d   = 2'b00;
          // The loser of this burst is favoured next: if 0 owned it, favour 1.
          pri_d   = gnt_q[0];
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: pure routing gated by state and owner
  // --------------------------------------------------------------------------
  always_comb begin
    M_ARVALID  = 1'b0;
    M_ARADDR   = sel1 ? S1_ARADDR  : S0_ARADDR;
    M_ARBURST  = sel1 ? S1_ARBURST : S0_ARBURST;
    M_ARLEN    = sel1 ? S1_ARLEN   : S0_ARLEN;
    M_RREADY   = 1'b0;
    S0_ARREADY = 1'b0;
    S1_ARREADY = 1'b0;
    S0_RVALID  = 1'b0;
    S1_RVALID  = 1'b0;
    S0_RLAST   = 1'b0;
    S1_RLAST   = 1'b0;
    // Data is broadcast; only the owner's RVALID qualifies it.
    S0_RDATA   = M_RDATA;
    S1_RDATA   = M_RDATA;
    case (state_q)
      ST_ADDR: begin
        // A requester dropping ARVALID early simply leaves M_ARVALID low.
        M_ARVALID  = sel1 ? S1_ARVALID : S0_ARVALID;
        S0_ARREADY = gnt_q[0] & M_ARREADY;
        S1_ARREADY = gnt_q[1] & M_ARREADY;
      end
      ST_DATA: begin
        M_RREADY  = sel1 ? S1_RREADY : S0_RREADY;
        S0_RVALID = gnt_q[0] & M_RVALID;
        S1_RVALID = gnt_q[1] & M_RVALID;
        S0_RLAST  = gnt_q[0] & M_RLAST;
        S1_RLAST  = gnt_q[1] & M_RLAST;
      end
      default: ;
    endcase
  end

  assign GNT  = gnt_q;
  assign BUSY = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_leve_axir_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_leve_axir_arb
// Purpose  : Self-checking bench for leve_axir_arb. Randomized requesters and
//            memory are checked every cycle against a transaction-level
//            reference model (current owner, address-phase-done flag, tie
//            favourite) built from the arbitration rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_leve_axir_arb;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        S0_ARVALID, S0_ARREADY, S0_RVALID, S0_RREADY, S0_RLAST;
  logic [63:0] S0_ARADDR, S0_RDATA;
  logic [1:0]  S0_ARBURST;
  logic [7:0]  S0_ARLEN;
  logic        S1_ARVALID, S1_ARREADY, S1_RVALID, S1_RREADY, S1_RLAST;
  logic [63:0] S1_ARADDR, S1_RDATA;
  logic [1:0]  S1_ARBURST;
  logic [7:0]  S1_ARLEN;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY, M_RLAST;
  logic [63:0] M_ARADDR, M_RDATA;
  logic [1:0]  M_ARBURST;
  logic [7:0]  M_ARLEN;
  logic [1:0]  GNT;
  logic        BUSY;

  leve_axir_arb dut (
    .CLK(CLK), .RSTn(RSTn),
    .S0_ARVALID(S0_ARVALID), .S0_ARREADY(S0_ARREADY), .S0_ARADDR(S0_ARADDR),
    .S0_ARBURST(S0_ARBURST), .S0_ARLEN(S0_ARLEN), .S0_RVALID(S0_RVALID),
    .S0_RREADY(S0_RREADY), .S0_RDATA(S0_RDATA), .S0_RLAST(S0_RLAST),
    .S1_ARVALID(S1_ARVALID), .S1_ARREADY(S1_ARREADY), .S1_ARADDR(S1_ARADDR),
    .S1_ARBURST(S1_ARBURST), .S1_ARLEN(S1_ARLEN), .S1_RVALID(S1_RVALID),
    .S1_RREADY(S1_RREADY), .S1_RDATA(S1_RDATA), .S1_RLAST(S1_RLAST),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR),
    .M_ARBURST(M_ARBURST), .M_ARLEN(M_ARLEN), .M_RVALID(M_RVALID),
    .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RLAST(M_RLAST),
    .GNT(GNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- stimulus knobs ----------------
  int req_prob[2];
  int rr_prob, ar_prob, rv_prob, max_len;
  bit spurious;
  bit fair_mode;
  int fair_cnt;

  // ---------------- requester state ----------------
  bit          arv[2];
  logic [63:0] addr[2];
  logic [1:0]  burst[2];
  logic [7:0]  alen[2];
  bit          rr[2];

  // ---------------- memory state ----------------
  bit          mem_active;
  int          mem_len, mem_beat;
  logic [63:0] mem_base;

  // ---------------- reference model ----------------
  int m_owner;     // -1 none, else requester index
  bit m_addr_done; // address phase of the current burst finished
  int m_pri;       // requester favoured on a tie
  bit new_grant;   // a grant was issued at the last edge

  task automatic model_reset();
    m_owner = -1; m_addr_done = 0; m_pri = 0; new_grant = 0;
    mem_active = 0; mem_beat = 0; mem_len = 0;
    arv[0] = 0; arv[1] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (!arv[i] && ($urandom % 100) < req_prob[i]) begin
        arv[i]   = 1;
        addr[i]  = {$urandom, $urandom};
        burst[i] = 2'($urandom % 3);
        alen[i]  = 8'($urandom % (max_len + 1));
      end
      rr[i] = ($urandom % 100) < rr_prob;
    end
    S0_ARVALID = arv[0]; S0_ARADDR = addr[0]; S0_ARBURST = burst[0]; S0_ARLEN = alen[0]; S0_RREADY = rr[0];
    S1_ARVALID = arv[1]; S1_ARADDR = addr[1]; S1_ARBURST = burst[1]; S1_ARLEN = alen[1]; S1_RREADY = rr[1];
    M_ARREADY = ($urandom % 100) < ar_prob;
    if (mem_active) begin
      M_RVALID = ($urandom % 100) < rv_prob;
      M_RLAST  = (mem_beat == mem_len);
      M_RDATA  = mem_base + 64'(mem_beat);
    end else begin
      M_RVALID = spurious && (($urandom % 100) < 40);
      M_RLAST  = 1'($urandom);
      M_RDATA  = {$urandom, $urandom};
    end
  endtask

  // One clock: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic cycle();
    bit       in_addr, in_data, e_marv, e_mrr;
    bit [1:0] e_gnt, e_arr, e_rv, e_rl;
    int       o;
    drive();
    #1;
    o       = m_owner;
    in_addr = (o >= 0) && !m_addr_done;
    in_data = (o >= 0) && m_addr_done;
    e_gnt   = (o < 0) ? 2'b00 : 2'(1 << o);
    e_marv  = in_addr && arv[o < 0 ? 0 : o];
    e_mrr   = in_data && rr[o < 0 ? 0 : o];
    e_arr   = (in_addr && M_ARREADY) ? e_gnt : 2'b00;
    e_rv    = (in_data && M_RVALID) ? e_gnt : 2'b00;
    e_rl    = (in_data && M_RLAST)  ? e_gnt : 2'b00;
    check("gnt", GNT, e_gnt);
    check("busy", BUSY, o >= 0);
    check("m_arvalid", M_ARVALID, e_marv);
    check("m_rready", M_RREADY, e_mrr);
    check("arready", {S1_ARREADY, S0_ARREADY}, e_arr);
    check("rvalid", {S1_RVALID, S0_RVALID}, e_rv);
    check("rlast", {S1_RLAST, S0_RLAST}, e_rl);
    if (e_marv) begin
      check("m_araddr", M_ARADDR, addr[o]);
      check("m_arburst", M_ARBURST, burst[o]);
      check("m_arlen", M_ARLEN, alen[o]);
    end
    if (in_data && M_RVALID) begin
      check("rdata", (o == 1) ? S1_RDATA : S0_RDATA, mem_base + 64'(mem_beat));
    end
    if (fair_mode && new_grant) begin
      check("fair_seq", GNT, (fair_cnt % 2) ? 2'b10 : 2'b01);
      fair_cnt++;
    end
    @(posedge CLK);
    new_grant = 0;
    if (!RSTn) begin
      model_reset();
    end else if (o < 0) begin
      if (arv[0] || arv[1]) begin
        m_owner     = (arv[0] && arv[1]) ? m_pri : (arv[1] ? 1 : 0);
        m_addr_done = 0;
        new_grant   = 1;
      end
    end else if (in_addr) begin
      if (e_marv && M_ARREADY) begin
        m_addr_done = 1;
        arv[o]      = 0;
        mem_active  = 1;
        mem_len     = int'(alen[o]);
        mem_beat    = 0;
        mem_base    = {$urandom, $urandom};
      end
    end else if (M_RVALID && e_mrr) begin
      if (M_RLAST) begin
        m_pri      = 1 - o;
        m_owner    = -1;
        mem_active = 0;
      end else begin
        mem_beat++;
      end
    end
    @(negedge CLK);
  endtask

  task automatic set_knobs(input int p0, input int p1, input int rrp, input int arp,
                           input int rvp, input int ml, input bit sp);
    req_prob[0] = p0; req_prob[1] = p1;
    rr_prob = rrp; ar_prob = arp; rv_prob = rvp; max_len = ml; spurious = sp;
  endtask

  initial begin
    int guard;
    model_reset();
    fair_mode = 0; fair_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; burst[i] = '0; alen[i] = '0; rr[i] = 0;
    end
    RSTn = 1'b0;
    set_knobs(0, 0, 50, 50, 50, 3, 1);
    @(negedge CLK);
    // Reset held with spurious memory data.
    for (int i = 0; i < 3; i++) cycle();
    RSTn = 1'b1;
    // Idle with spurious memory data: nothing may be routed.
    for (int i = 0; i < 5; i++) cycle();

    // Fairness: both always requesting, single-beat bursts.
    set_knobs(100, 100, 100, 100, 100, 0, 0);
    fair_mode = 1;
    guard = 0;
    while (fair_cnt < 6 && guard < 200) begin cycle(); guard++; end
    if (fair_cnt < 6) check("fair_timeout", 1'b0, 1'b1);
    fair_mode = 0;
    set_knobs(0, 0, 100, 100, 100, 0, 0);
    for (int i = 0; i < 10; i++) cycle();

    // Backpressure on requester 0 only.
    set_knobs(60, 0, 50, 20, 60, 3, 1);
    for (int i = 0; i < 300; i++) cycle();

    // Full random contention.
    set_knobs(40, 40, 60, 50, 60, 5, 1);
    for (int i = 0; i < 2000; i++) cycle();

    // Reset in the middle of a 4-beat burst owned by requester 0.
    set_knobs(0, 0, 100, 100, 100, 3, 0);
    guard = 0;
    while (m_owner >= 0 && guard < 200) begin cycle(); guard++; end
    arv[1] = 0;
    req_prob[0] = 100; max_len = 3;
    guard = 0;
    while (!(m_owner == 0 && m_addr_done && mem_beat == 2 && mem_len == 3) && guard < 400) begin
      cycle(); guard++;
      if (m_owner < 0) begin
        req_prob[0] = (arv[0]) ? 0 : 100;
      end
    end
    if (guard >= 400) check("rst_wait_timeout", 1'b0, 1'b1);
    RSTn = 1'b0;
    M_RVALID = 1'b1; M_ARREADY = 1'b1; M_RLAST = 1'b0;
    #1;
    check("rst_async_gnt", GNT, 2'b00);
    check("rst_async_busy", BUSY, 1'b0);
    check("rst_async_m_arvalid", M_ARVALID, 1'b0);
    check("rst_async_m_rready", M_RREADY, 1'b0);
    check("rst_async_rvalid", {S1_RVALID, S0_RVALID}, 2'b00);
    @(negedge CLK);
    model_reset();
    set_knobs(0, 0, 100, 100, 100, 3, 0);
    cycle();
    RSTn = 1'b1;
    req_prob[1] = 100;
    guard = 0;
    while (!new_grant && guard < 20) begin cycle(); guard++; end
    if (!new_grant) check("rst_regrant_timeout", 1'b0, 1'b1);
    check("rst_then_s1_gnt", GNT, 2'b10);
    req_prob[1] = 0;
    for (int i = 0; i < 30; i++) cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/leve_axir_arb.md
Name: leve_axir_arb

Overview:
Two-to-one AXI read-channel arbiter. It shares the core's single read initiator port between the instruction burst buffer (requester 0) and the future load/store unit (requester 1). It grants whole bursts, from AR handshake through the R beat carrying RLAST, with round-robin fairness. Only one transaction is outstanding at a time, so no ID routing is needed.

Parameters:
ADDR_W, 64, AR address width (XLEN)
DATA_W, 64, R data width
LEN_W, 8, ARLEN width

Ports:
CLK  in  1  clock
RSTn  in  1  reset, asynchronous, active-low
S0_ARVALID  in  1  requester 0 (ifetch) address valid
S0_ARREADY  out  1  requester 0 address ready
S0_ARADDR  in  ADDR_W  requester 0 address
S0_ARBURST  in  2  requester 0 burst type
S0_ARLEN  in  LEN_W  requester 0 beats minus 1
S0_RVALID  out  1  requester 0 read data valid
S0_RREADY  in  1  requester 0 read data ready
S0_RDATA  out  DATA_W  requester 0 read data
S0_RLAST  out  1  requester 0 last beat
S1_*  same set as S0_*, requester 1 (data)
M_ARVALID  out  1  to memory: address valid
M_ARREADY  in  1  from memory: address ready
M_ARADDR  out  ADDR_W  to memory: address
M_ARBURST  out  2  to memory: burst type
M_ARLEN  out  LEN_W  to memory: burst length
M_RVALID  in  1  from memory: data valid
M_RREADY  out  1  to memory: data ready
M_RDATA  in  DATA_W  from memory: data
M_RLAST  in  1  from memory: last beat
GNT  out  2  one-hot current owner (00 = none)
BUSY  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock CLK; RSTn is asynchronous and active-low. Everything else is synchronous to the CLK rising edge.
- State machine: IDLE, ADDR, DATA. State, GNT and the priority pointer PRI are registered.
- Reset values: state=IDLE, GNT=00, PRI=0 (requester 0 favoured), BUSY=0. All ARREADY/RVALID/M_ARVALID/M_RREADY outputs are 0 while in IDLE.
- IDLE:
  - If exactly one Sx_ARVALID is high, grant that requester.
  - If both are high, grant requester PRI.
  - On grant: next state=ADDR, GNT<=one-hot(winner).
  - With no request, stay in IDLE.
  - Latency: a request seen in cycle N produces M_ARVALID=1 in cycle N+1.
- ADDR:
  - M_ARVALID/ARADDR/ARBURST/ARLEN are combinational pass-through of the granted requester.
  - Granted Sx_ARREADY = M_ARREADY. The other requester's ARREADY = 0.
  - On M_ARVALID & M_ARREADY, next state=DATA.
  - A granted requester that drops ARVALID before its handshake violates AXI. In that case the arbiter stays in ADDR with M_ARVALID=0; no recovery is defined.
- DATA:
  - Granted Sx_RVALID = M_RVALID; Sx_RDATA and Sx_RLAST pass through; M_RREADY = granted Sx_RREADY.
  - The non-granted requester sees RVALID=0, RLAST=0, and RDATA equal to M_RDATA (don't care).
  - On M_RVALID & M_RREADY & M_RLAST: next state=IDLE, GNT<=00, PRI<=~winner (the loser of this burst is favoured next).
- M_RVALID while in IDLE or ADDR is ignored and M_RREADY is held 0 (protocol error at memory).
- Back-to-back bursts: the IDLE cycle after RLAST is mandatory. Minimum gap is 1 cycle between the RLAST handshake and the next M_ARVALID.
- Non-granted ARVALID is held off (ARREADY=0) indefinitely until the current burst ends. Round-robin bounds its wait to one burst of the other requester.
- Reset asserted mid-burst: immediate return to IDLE and reset values. In-flight beats are discarded; the memory side must itself be reset.
- M_RREADY is never asserted in IDLE or ADDR.
- Size: roughly 150-220 lines of RTL.

Test Plan:
- Single request: S0 ARVALID, ARADDR=0x1000, ARLEN=3 -> GNT=01 next cycle, M_ARADDR=0x1000; 4 beats routed to S0 only, S1_RVALID=0 throughout; GNT=00 the cycle after RLAST.
- Simultaneous after reset: S0 and S1 both raise ARVALID in the same cycle -> S0 granted first (PRI=0); after its RLAST, S1 granted after 1 IDLE cycle; then PRI=0.
- Fairness: both requesters always requesting, 6 bursts of ARLEN=0 -> grant sequence 0,1,0,1,0,1; no requester waits more than one burst.
- Backpressure: M_ARREADY low for 5 cycles, then S0 RREADY toggling 1,0,1,0 -> M_ARVALID held stable with ARADDR unchanged; M_RREADY mirrors S0_RREADY; no beat is lost or duplicated (check RDATA sequence 0..3).
- Reset mid-burst: assert RSTn=0 after 2 of 4 beats -> asynchronously GNT=00, BUSY=0, all valids 0; after release, a fresh S1 request is granted normally.
- Spurious data: M_RVALID=1 while IDLE -> M_RREADY=0, S0_RVALID=S1_RVALID=0, state unchanged.
